// File: rtl/universal_register_n.sv
// WIDTH-bit register with hold, load, shift, rotate and up/down count modes.
// Provides complementary and serial-tap outputs plus a registered terminal-count pulse.
module universal_register_n #(
   parameter int          WIDTH       = 4,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic             input_clock1_1,
   input  logic             input_reset1_2,
   input  logic             input_enable_3,
   input  logic [2:0]       input_mode_4,
   input  logic [WIDTH-1:0] input_data_5,
   input  logic             input_serial_in_6,
   output logic [WIDTH-1:0] output_q_7,
   output logic [WIDTH-1:0] output_qn_8,
   output logic             output_msb_9,
   output logic             output_lsb_10,
   output logic             output_tc_11
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
      $error("universal_register_n: WIDTH must be in 2..32");
   end

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_LOAD  = 3'b001,
      MODE_SHL   = 3'b010,
      MODE_SHR   = 3'b011,
      MODE_ROL   = 3'b100,
      MODE_ROR   = 3'b101,
      MODE_UP    = 3'b110,
      MODE_DOWN  = 3'b111
   } mode_t;

   localparam logic [WIDTH-1:0] RST_Q    = RESET_VALUE[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   // Initialisers give the reset state at power-up, before any reset edge.
   logic [WIDTH-1:0] q_p0  = RST_Q;
   logic             tc_p0 = 1'b0;

   logic [WIDTH-1:0] q_next;
   logic             wrap;
   mode_t            mode;

   assign mode = mode_t'(input_mode_4);

   always_comb begin
      q_next = q_p0;
      wrap   = 1'b0;
      case (mode)
         MODE_HOLD: q_next = q_p0;
         MODE_LOAD: q_next = input_data_5;
         MODE_SHL:  q_next = {q_p0[WIDTH-2:0], input_serial_in_6};
         MODE_SHR:  q_next = {input_serial_in_6, q_p0[WIDTH-1:1]};
         MODE_ROL:  q_next = {q_p0[WIDTH-2:0], q_p0[WIDTH-1]};
         MODE_ROR:  q_next = {q_p0[0], q_p0[WIDTH-1:1]};
         MODE_UP: begin
            q_next = q_p0 + 1'b1;
            wrap   = (q_p0 == ALL_ONES);
         end
         MODE_DOWN: begin
            q_next = q_p0 - 1'b1;
            wrap   = (q_p0 == '0);
         end
         default: q_next = q_p0;
      endcase
   end

   // Stage p0: Q register and terminal-count flop; reset > enable > mode.
   always_ff @(posedge input_clock1_1) begin
      if (input_reset1_2) begin
         q_p0  <= RST_Q;
         tc_p0 <= 1'b0;
      end else if (!input_enable_3) begin
         tc_p0 <= 1'b0;
      end else begin
         q_p0  <= q_next;
         tc_p0 <= wrap;
      end
   end

   assign output_q_7    = q_p0;
   assign output_qn_8   = ~q_p0;
   assign output_msb_9  = q_p0[WIDTH-1];
   assign output_lsb_10 = q_p0[0];
   assign output_tc_11  = tc_p0;

endmodule

// File: tb/tb_universal_register_n.sv
// Self-checking bench for universal_register_n (WIDTH=4, RESET_VALUE=4'hA):
// directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_universal_register_n;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [3:0] data = 4'h0;
   logic       sin = 1'b0;
   logic [3:0] q, qn;
   logic       msb, lsb, tc;

   int total = 0;
   int bad = 0;
   int mq = 10;
   int mtc = 0;

   always #5 clk = ~clk;

   universal_register_n #(.WIDTH(4), .RESET_VALUE(32'hA)) dut (
      .input_clock1_1   (clk),
      .input_reset1_2   (rst),
      .input_enable_3   (en),
      .input_mode_4     (mode),
      .input_data_5     (data),
      .input_serial_in_6(sin),
      .output_q_7       (q),
      .output_qn_8      (qn),
      .output_msb_9     (msb),
      .output_lsb_10    (lsb),
      .output_tc_11     (tc)
   );

   // Apply one cycle of inputs, wait for the edge, and advance the reference model.
   task automatic drive(input logic r, input logic e, input logic [2:0] m,
                        input logic [3:0] d, input logic s);
      int nq;
      rst = r; en = e; mode = m; data = d; sin = s;
      @(posedge clk);
      #1;
      nq = mq;
      if (r) begin
         nq = 10; mtc = 0;
      end else if (!e) begin
         mtc = 0;
      end else begin
         mtc = 0;
         case (m)
            3'd1: nq = int'(d);
            3'd2: nq = (mq * 2 + int'(s)) % 16;
            3'd3: nq = int'(s) * 8 + mq / 2;
            3'd4: nq = (mq * 2) % 16 + mq / 8;
            3'd5: nq = (mq % 2) * 8 + mq / 2;
            3'd6: begin nq = (mq + 1) % 16; mtc = (mq == 15) ? 1 : 0; end
            3'd7: begin nq = (mq + 15) % 16; mtc = (mq == 0) ? 1 : 0; end
            default: nq = mq;
         endcase
      end
      mq = nq;
   endtask

   task automatic test_reset();
      drive(1, 1, 3'b110, 4'h0, 0);
      total++; if (q !== 4'hA) begin bad++; $display("FAIL reset_q got=%h want=a", q); end
      total++; if (qn !== 4'h5) begin bad++; $display("FAIL reset_qn got=%h want=5", qn); end
      total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b want=0", tc); end
      total++; if (msb !== 1'b1 || lsb !== 1'b0)
         begin bad++; $display("FAIL reset_taps got msb=%b lsb=%b want msb=1 lsb=0", msb, lsb); end
   endtask

   task automatic test_shift_left();
      logic [3:0] exp [3] = '{4'h7, 4'hE, 4'hD};
      logic       sv  [3] = '{1'b1, 1'b0, 1'b1};
      drive(0, 1, 3'b001, 4'h3, 0);
      total++; if (q !== 4'h3 || qn !== 4'hC) begin bad++; $display("FAIL load3 got q=%h qn=%h want q=3 qn=c", q, qn); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 3'b010, 4'h0, sv[i]);
         total++;
         if (q !== exp[i] || qn !== ~exp[i]) begin
            bad++; $display("FAIL shl_%0d got q=%h qn=%h want q=%h qn=%h", i, q, qn, exp[i], ~exp[i]);
         end
      end
   endtask

   task automatic test_rotate();
      logic [3:0] exp [4] = '{4'hC, 4'h6, 4'h3, 4'h9};
      drive(0, 1, 3'b001, 4'h9, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 3'b101, 4'h0, 1);
         total++;
         if (q !== exp[i]) begin bad++; $display("FAIL ror_%0d got=%h want=%h", i, q, exp[i]); end
      end
      drive(0, 1, 3'b011, 4'h0, 0);
      total++; if (q !== 4'h4) begin bad++; $display("FAIL shr got=%h want=4", q); end
      drive(0, 1, 3'b100, 4'h0, 0);
      total++; if (q !== 4'h8 || msb !== 1'b1 || lsb !== 1'b0)
         begin bad++; $display("FAIL rol got q=%h msb=%b lsb=%b want q=8 msb=1 lsb=0", q, msb, lsb); end
   endtask

   task automatic test_count();
      logic [3:0] exp [3] = '{4'hF, 4'h0, 4'h1};
      logic       etc [3] = '{1'b0, 1'b1, 1'b0};
      drive(0, 1, 3'b001, 4'hE, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 3'b110, 4'h0, 0);
         total++;
         if (q !== exp[i] || tc !== etc[i]) begin
            bad++; $display("FAIL up_%0d got q=%h tc=%b want q=%h tc=%b", i, q, tc, exp[i], etc[i]);
         end
      end
      drive(0, 1, 3'b001, 4'h0, 0);
      drive(0, 1, 3'b111, 4'h0, 0);
      total++; if (q !== 4'hF || tc !== 1'b1) begin bad++; $display("FAIL down_wrap got q=%h tc=%b want q=f tc=1", q, tc); end
      drive(0, 1, 3'b111, 4'h0, 0);
      total++; if (q !== 4'hE || tc !== 1'b0) begin bad++; $display("FAIL down_after got q=%h tc=%b want q=e tc=0", q, tc); end
   endtask

   task automatic test_enable();
      logic [3:0] exp [4] = '{4'h1, 4'h1, 4'h2, 4'h2};
      logic       ev  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      drive(0, 1, 3'b001, 4'h0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(0, ev[i], 3'b110, 4'h0, 0);
         total++;
         if (q !== exp[i] || tc !== 1'b0) begin
            bad++; $display("FAIL en_%0d got q=%h tc=%b want q=%h tc=0", i, q, tc, exp[i]);
         end
      end
      drive(0, 1, 3'b001, 4'hF, 0);
      drive(0, 0, 3'b110, 4'h0, 0);
      total++; if (q !== 4'hF || tc !== 1'b0) begin bad++; $display("FAIL en_off_wrap got q=%h tc=%b want q=f tc=0", q, tc); end
   endtask

   task automatic test_reset_wrap();
      drive(0, 1, 3'b001, 4'hE, 0);
      drive(0, 1, 3'b110, 4'h0, 0);
      drive(1, 1, 3'b110, 4'h0, 0);
      total++; if (q !== 4'hA || tc !== 1'b0) begin bad++; $display("FAIL rst_wrap got q=%h tc=%b want q=a tc=0", q, tc); end
      drive(0, 1, 3'b110, 4'h0, 0);
      total++; if (q !== 4'hB || tc !== 1'b0) begin bad++; $display("FAIL rst_resume got q=%h tc=%b want q=b tc=0", q, tc); end
   endtask

   task automatic test_random();
      logic r, e, s;
      logic [2:0] m;
      logic [3:0] d, eq;
      drive(1, 0, 3'b000, 4'h0, 0);
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 19) == 0);
         e = ($urandom_range(0, 4) != 0);
         m = 3'($urandom_range(0, 7));
         d = 4'($urandom);
         s = 1'($urandom);
         drive(r, e, m, d, s);
         eq = 4'(mq);
         total++;
         if (q !== eq || qn !== ~eq || msb !== eq[3] || lsb !== eq[0] || tc !== 1'(mtc)) begin
            bad++;
            $display("FAIL rand_%0d got q=%h qn=%h msb=%b lsb=%b tc=%b want q=%h tc=%0d",
                     i, q, qn, msb, lsb, tc, eq, mtc);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1;
      total++; if (q !== 4'hA || tc !== 1'b0) begin bad++; $display("FAIL powerup got q=%h tc=%b want q=a tc=0", q, tc); end
      test_reset();
      test_shift_left();
      test_rotate();
      test_count();
      test_enable();
      test_reset_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
